shield_ram_fifo_ctrl: RTL and testbench
=======================================

Name: shield_ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives an external simple-dual-port RAM, i.e. the block that produces wr_addr/wr_en/wr_data/rd_addr and consumes rd_data.
- The RAM has a 1-cycle registered read and read-old-data on same-address collision.
- The controller adds a 2-entry prefetch buffer, so the output valid/ready stream runs at one word per cycle despite the RAM read latency.
- It sits between a producer stream and a consumer stream inside the shield datapath, for example for buffering outbound ciphertext bursts.

Parameters:
- DATA_WIDTH, 512, word width; must equal the attached RAM's DATA_WIDTH.
- ADDR_WIDTH, 8, RAM address width; RAM depth is 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock for all logic; the attached RAM shares it.
- rst  input  1  synchronous, active-high reset.
- s_data  input  DATA_WIDTH  write-side data.
- s_valid  input  1  write-side valid.
- s_ready  output  1  write-side ready.
- m_data  output  DATA_WIDTH  read-side data (head of FIFO).
- m_valid  output  1  read-side valid.
- m_ready  input  1  read-side ready.
- ram_wr_addr  output  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_en  output  1  to RAM wr_en.
- ram_wr_data  output  DATA_WIDTH  to RAM wr_data.
- ram_rd_addr  output  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  input  DATA_WIDTH  from RAM rd_data, valid the cycle after a read is issued.
- count  output  ADDR_WIDTH+2  total words held.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, with MSB wrap.
  - ram_cnt = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - rd_pending, 1 bit.
  - out_buf: 2 entries, with head/tail index and out_cnt in 0..2.
- Reset, while rst is high and on the first cycle after:
  - wr_ptr = rd_ptr = 0, rd_pending = 0, out_cnt = 0.
  - m_valid = 0, count = 0, ram_wr_en = 0.
  - s_ready = 0 while rst is high, and 1 on the first cycle after rst falls.
  - m_data is don't-care when m_valid = 0.
- Reset mid-operation discards all contents. A read in flight at reset is dropped; its rd_data is ignored.
- Push:
  - push = s_valid & s_ready, where s_ready = !rst & (ram_cnt != 2^ADDR_WIDTH), computed from registered state only.
  - On push: ram_wr_en = 1, ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0], ram_wr_data = s_data (combinational pass-through), and wr_ptr increments at the edge.
- Read issue:
  - issue = !rst & (ram_cnt != 0) & (out_cnt + rd_pending - pop < 2).
  - ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0] at all times.
  - On issue, rd_ptr increments and rd_pending <= 1; otherwise rd_pending <= 0.
  - Because ram_cnt is registered, an entry is never read in the cycle it is written, so no collision case exists.
- Capture: when rd_pending = 1, ram_rd_data is written to the out_buf tail at the edge.
- Pop:
  - pop = m_valid & m_ready.
  - m_valid = (out_cnt != 0); m_data = the out_buf head entry.
  - On pop, head advances.
  - Capture and pop in the same cycle are both applied; out_cnt changes by capture - pop.
- Full throughput: with the RAM non-empty and m_ready held high, one word pops per cycle with no bubbles.
- Latency into an empty FIFO: push in cycle N, read issued in N+1, capture at the end of N+2, m_valid = 1 in N+3 with the pushed data.
- Ordering: strict FIFO; words pop in push order, including across pointer wrap.
- count = ram_cnt + rd_pending + out_cnt. Maximum is 2^ADDR_WIDTH + 2.
- Full: s_ready = 0 when ram_cnt = 2^ADDR_WIDTH. It re-asserts the cycle after an issue frees a RAM slot.
- Simultaneous push and issue on the same cycle are both honoured (different slots).
- Handshake rules:
  - m_data and m_valid are stable while m_valid = 1 and m_ready = 0.
  - s_valid may drop without a handshake.
  - No combinational path from m_ready to s_ready.

Test Plan:
- Reset, then a single push of 0xA5 in cycle 0 → ram_wr_en=1, ram_wr_addr=0 in cycle 0; m_valid=1, m_data=0xA5 in cycle 3; count=1 from cycle 1 until pop.
- ADDR_WIDTH=4, m_ready=0, 20 pushes of 0..19 offered back-to-back → 18 accepted (16 RAM + 2 prefetch); s_ready=0 thereafter; count=18; then m_ready=1 → data 0..17 pop in order, one per cycle, with no bubbles.
- Streaming with s_valid=1 and m_ready=1 for 100 words (ADDR_WIDTH=4, forcing wrap several times) → output sequence equals input sequence; steady-state throughput 1/cycle after the 3-cycle fill.
- Backpressure: m_ready toggled pseudo-randomly during a 50-word stream → m_data is held stable while stalled, no drops or duplicates; count matches the scoreboard every cycle.
- Assert rst for one cycle with count=7 and a read in flight → next cycle count=0, m_valid=0, s_ready=1; a subsequent push of 0x3C emerges as the first word 3 cycles later.
- Full boundary (ADDR_WIDTH=4): at ram_cnt=16 with a pop and an issue occurring → s_ready rises the next cycle, and a push that cycle writes to the freed address in wrap order.

Source files
------------

// File: rtl/shield_ram_fifo_ctrl.sv
// FIFO controller for an external simple-dual-port RAM with a 1-cycle registered read.
// A 2-entry prefetch buffer hides the read latency so the output streams one word per cycle.
module shield_ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH+1:0] count
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
    logic                  rd_pending_q, rd_pending_d;
    logic [DATA_WIDTH-1:0] out_buf_q [2];
    logic                  head_q, head_d, tail_q, tail_d;
    logic [1:0]            out_cnt_q, out_cnt_d;
    logic [2:0]            occ;
    logic                  push, pop, issue;

    always_comb begin
        ram_cnt = wr_ptr_q - rd_ptr_q;
        s_ready = !rst && (ram_cnt != DEPTH);
        push    = s_valid && s_ready;
        m_valid = !rst && (out_cnt_q != 2'd0);
        pop     = m_valid && m_ready;
        // Words already committed to the output side (buffered or in flight).
        occ     = {1'b0, out_cnt_q} + {2'b0, rd_pending_q};
        issue   = !rst && (ram_cnt != '0) && (occ < (3'd2 + {2'b0, pop}));

        m_data      = out_buf_q[head_q];
        ram_wr_en   = push;
        ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
        ram_wr_data = s_data;
        ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        count       = rst ? '0 : ({1'b0, ram_cnt} + (ADDR_WIDTH+2)'(rd_pending_q)
                                  + (ADDR_WIDTH+2)'(out_cnt_q));

        wr_ptr_d     = wr_ptr_q + (ADDR_WIDTH+1)'(push);
        rd_ptr_d     = rd_ptr_q + (ADDR_WIDTH+1)'(issue);
        rd_pending_d = issue;
        tail_d       = rd_pending_q ? ~tail_q : tail_q;
        head_d       = pop ? ~head_q : head_q;
        out_cnt_d    = out_cnt_q + {1'b0, rd_pending_q} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            out_cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    // Data storage needs no reset; a read in flight at reset is dropped by the gate.
    always_ff @(posedge clk) begin
        if (!rst && rd_pending_q) out_buf_q[tail_q] <= ram_rd_data;
    end
endmodule

// File: tb/tb_shield_ram_fifo_ctrl.sv
// Bench for shield_ram_fifo_ctrl: behavioural RAM, word-queue scoreboard and handshake monitor.
module tb_shield_ram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data, m_data, ram_wr_data, ram_rd_data;
    logic          s_valid, s_ready, m_valid, m_ready, ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [AW+1:0] count;

    shield_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .count(count)
    );

    always #5 clk = ~clk;

    // Simple-dual-port RAM, registered read, old data on collision.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    int n_tests = 0, n_fail = 0, n_pop = 0;
    logic [DW-1:0] sb [$];
    int  mcnt = 0, widx = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: reference model is the ordered list of accepted words; occupancy = pushes - pops.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_count", count, 0);
            sb.delete();
            mcnt = 0; widx = 0; prev_stall = 1'b0;
        end else begin
            chk("count", count, mcnt);
            if (prev_stall) begin
                chk("stall_m_valid", m_valid, 1);
                chk("stall_m_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pop_empty: got %0h expected no word", m_data);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", m_data, e);
                end
                mcnt--; n_pop++;
            end
            if (s_valid && s_ready) begin
                chk("wr_en", ram_wr_en, 1);
                chk("wr_addr", ram_wr_addr, widx % (1 << AW));
                chk("wr_data", ram_wr_data, s_data);
                sb.push_back(s_data);
                mcnt++; widx++;
            end else begin
                chk("wr_en_idle", ram_wr_en, 0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        next();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        s_valid = 1'b0; m_ready = 1'b1;
        while (sb.size() != 0 && c < budget) begin next(); c++; end
        chk("drain_done", sb.size(), 0);
        m_ready = 1'b0;
    endtask

    initial begin
        int k, streak, p0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        next(); next();

        // Single word latency
        rst = 1'b0; s_valid = 1'b1; s_data = 32'hA5;
        @(negedge clk); chk("first_s_ready", s_ready, 1); chk("t1_wr_addr", ram_wr_addr, 0);
        next(); s_valid = 1'b0;
        @(negedge clk); chk("t1_mv_c1", m_valid, 0); chk("t1_count_c1", count, 1);
        next();
        @(negedge clk); chk("t1_mv_c2", m_valid, 0);
        next(); m_ready = 1'b1;
        @(negedge clk); chk("t1_mv_c3", m_valid, 1); chk("t1_md_c3", m_data, 32'hA5);
        next(); m_ready = 1'b0;
        @(negedge clk); chk("t1_mv_c4", m_valid, 0);
        next();

        // Fill to capacity, then the full boundary
        do_reset();
        k = 0;
        for (int c = 0; c < 24; c++) begin
            s_valid = 1'b1; s_data = k;
            @(negedge clk); if (s_ready) k++;
            next();
        end
        s_valid = 1'b0;
        chk("fill_accepted", k, 18);
        @(negedge clk); chk("fill_count", count, 18); chk("fill_s_ready", s_ready, 0);
        next(); m_ready = 1'b1;
        @(negedge clk); chk("full_s_ready_pop", s_ready, 0);
        next(); m_ready = 1'b0; s_valid = 1'b1; s_data = 100;
        @(negedge clk); chk("full_s_ready_rise", s_ready, 1); chk("full_wr_addr", ram_wr_addr, 2);
        next(); s_valid = 1'b0;
        @(negedge clk); chk("full_again", s_ready, 0);
        next(); m_ready = 1'b1; streak = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk); if (m_valid) streak++;
            next();
        end
        m_ready = 1'b0;
        chk("drain_no_bubble", streak, 18);
        @(negedge clk); chk("drain_empty", m_valid, 0);
        next();

        // Streaming through several wraps at full rate
        do_reset();
        m_ready = 1'b1; p0 = n_pop;
        for (int c = 0; c < 100; c++) begin
            s_valid = 1'b1; s_data = $urandom;
            next();
        end
        s_valid = 1'b0;
        repeat (3) next();
        chk("stream_pops", n_pop - p0, 100);
        drain(20);

        // Random backpressure
        do_reset();
        k = 0;
        for (int c = 0; c < 2000 && k < 50; c++) begin
            s_valid = ($urandom % 4) != 0; s_data = $urandom; m_ready = $urandom % 2;
            @(negedge clk); if (s_valid && s_ready) k++;
            next();
        end
        chk("bp_accepted", k, 50);
        drain(200);
        next();

        // Reset mid-operation with a read in flight
        do_reset();
        for (int c = 0; c < 9; c++) begin
            s_valid = 1'b1; s_data = 32'h1000 + c;
            next();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        next(); next();
        m_ready = 1'b0;
        chk("pre_rst_count", count, 7);
        rst = 1'b1;
        next();
        rst = 1'b0; s_valid = 1'b1; s_data = 32'h3C;
        @(negedge clk); chk("post_rst_count", count, 0); chk("post_rst_mv", m_valid, 0);
        chk("post_rst_s_ready", s_ready, 1);
        next(); s_valid = 1'b0;
        next(); next();
        @(negedge clk); chk("post_rst_mv3", m_valid, 1); chk("post_rst_md3", m_data, 32'h3C);
        drain(10);
        next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
